// File: rtl/program_loader.sv
// Host-side programming sequencer for the 8-bit CPU: buffers a program image
// from the host byte stream, feeds it to the CPU during LOAD, then supervises
// the run and captures the CPU output on halt.
module program_loader #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned PROG_BYTES = 16,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     start,
    input  logic                     abort,
    output logic [7:0]               cpu_ui_in,
    output logic                     cpu_programming,
    input  logic                     cpu_ready,
    input  logic                     cpu_done_load,
    input  logic                     cpu_halt,
    input  logic [7:0]               cpu_out,
    output logic                     busy,
    output logic                     halted,
    output logic                     error,
    output logic [1:0]               err_code,
    output logic [7:0]               result,
    output logic [15:0]              run_cycles,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(PROG_BYTES) + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [AW:0]   PROG_CNT   = (AW + 1)'(PROG_BYTES);
    localparam logic [AW:0]   FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t state, state_next;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          cpu_ready_q, cpu_done_q;
    logic [SW-1:0] sent;
    logic [TW-1:0] timer;

    logic consume, done_rise, push, pop, flush, load_go;
    logic set_err, timer_clr, timer_inc, run_inc, latch_result;
    logic [1:0] err_val;

    assign consume    = cpu_ready_q & ~cpu_ready;
    assign done_rise  = ~cpu_done_q & cpu_done_load;
    assign push       = s_valid & s_ready;
    assign fifo_count = count;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic, datapath controls and state-decoded outputs
    always_comb begin
        state_next   = state;
        pop          = 1'b0;
        flush        = 1'b0;
        load_go      = 1'b0;
        set_err      = 1'b0;
        err_val      = 2'd0;
        timer_clr    = 1'b0;
        timer_inc    = 1'b0;
        run_inc      = 1'b0;
        latch_result = 1'b0;

        cpu_programming = (state == S_LOAD);
        busy            = (state == S_LOAD) || (state == S_RUN);
        halted          = (state == S_HALTED);
        error           = (state == S_ERROR);
        s_ready         = (count != FULL_CNT) && (state != S_ERROR);
        cpu_ui_in       = (state == S_LOAD) ? mem[rd_ptr] : 8'h00;

        if (abort) begin
            state_next = S_IDLE;
            flush      = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        if (count >= PROG_CNT) begin
                            state_next = S_LOAD;
                            load_go    = 1'b1;
                        end else begin
                            state_next = S_ERROR;
                            set_err    = 1'b1;
                            err_val    = 2'd3;
                        end
                    end
                end
                S_LOAD: begin
                    // done_load wins over a coincident consume, but the
                    // byte handed over in that cycle is still popped
                    if (done_rise) begin
                        state_next = S_RUN;
                        timer_clr  = 1'b1;
                        pop        = consume && (count != '0);
                    end else if (consume) begin
                        if (count == '0) begin
                            state_next = S_ERROR;
                            set_err    = 1'b1;
                            err_val    = 2'd1;
                        end else begin
                            pop       = 1'b1;
                            timer_clr = 1'b1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state_next = S_ERROR;
                        set_err    = 1'b1;
                        err_val    = 2'd2;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
                S_RUN: begin
                    run_inc = 1'b1;
                    if (cpu_halt) begin
                        state_next   = S_HALTED;
                        latch_result = 1'b1;
                    end
                end
                S_ERROR: ;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // FIFO storage, written without reset
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= s_data;
    end

    // FIFO pointers, handshake edge registers, counters and captured results
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cpu_ready_q <= 1'b0;
            cpu_done_q  <= 1'b0;
            sent        <= '0;
            timer       <= '0;
            run_cycles  <= '0;
            result      <= '0;
            err_code    <= '0;
        end else begin
            cpu_ready_q <= cpu_ready;
            cpu_done_q  <= cpu_done_load;

            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                err_code <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
                if (set_err) err_code <= err_val;
            end

            if (load_go) begin
                sent       <= '0;
                timer      <= '0;
                run_cycles <= '0;
            end else begin
                if (pop) sent <= sent + 1'b1;
                if (timer_clr)      timer <= '0;
                else if (timer_inc) timer <= timer + 1'b1;
                if (run_inc && (run_cycles != 16'hFFFF))
                    run_cycles <= run_cycles + 1'b1;
            end

            if (latch_result) result <= cpu_out;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: start-decision vector table plus
// hand-written load/run sequences with a byte scoreboard for cpu_ui_in.
module tb_program_loader;
    localparam int DEPTH = 16;
    localparam int PB    = 16;
    localparam int TO    = 255;

    logic        clk = 1'b0;
    logic        rst, s_valid, s_ready, start, abort;
    logic [7:0]  s_data, cpu_ui_in, cpu_out, result;
    logic        cpu_programming, cpu_ready, cpu_done_load, cpu_halt;
    logic        busy, halted, error;
    logic [1:0]  err_code;
    logic [15:0] run_cycles;
    logic [4:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;
    int model_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        int         npush;
        logic       exp_busy;
        logic       exp_err;
        logic [1:0] exp_code;
    } vec_t;
    vec_t vecs[5];

    program_loader #(.DEPTH(DEPTH), .PROG_BYTES(PB), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .start(start), .abort(abort), .cpu_ui_in(cpu_ui_in),
        .cpu_programming(cpu_programming), .cpu_ready(cpu_ready),
        .cpu_done_load(cpu_done_load), .cpu_halt(cpu_halt), .cpu_out(cpu_out),
        .busy(busy), .halted(halted), .error(error), .err_code(err_code),
        .result(result), .run_cycles(run_cycles), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            logic       acc;
            d   = base + 8'(i);
            acc = (model_cnt < DEPTH);
            s_data  = d;
            s_valid = 1'b1;
            check("s_ready", 32'(s_ready), 32'(acc));
            tick;
            if (acc) begin
                model_cnt++;
                exp_q.push_back(d);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic cpu_byte;
        cpu_ready = 1'b1;
        tick;
        check("programming", 32'(cpu_programming), 32'd1);
        if (exp_q.size() > 0) begin
            check("cpu_ui_in", 32'(cpu_ui_in), 32'(exp_q.pop_front()));
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: empty, got 0x%0h", cpu_ui_in);
        end
        cpu_ready = 1'b0;
        tick;
        model_cnt--;
        check("fifo_count", 32'(fifo_count), 32'(model_cnt));
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic pulse_done;
        cpu_done_load = 1'b1;
        tick;
        cpu_done_load = 1'b0;
    endtask

    task automatic do_halt(input logic [7:0] v);
        cpu_out  = v;
        cpu_halt = 1'b1;
        tick;
        cpu_halt = 1'b0;
    endtask

    task automatic do_abort;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        model_cnt = 0;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_prog"},   32'(cpu_programming), 32'd0);
        check({tag, "_ui_in"},  32'(cpu_ui_in), 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_error"},  32'(error), 32'd0);
        check({tag, "_code"},   32'(err_code), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_cycles"}, 32'(run_cycles), 32'd0);
        check({tag, "_count"},  32'(fifo_count), 32'd0);
        check({tag, "_sready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        int n;
        vecs[0] = '{npush: 0,  exp_busy: 1'b0, exp_err: 1'b1, exp_code: 2'd3};
        vecs[1] = '{npush: 10, exp_busy: 1'b0, exp_err: 1'b1, exp_code: 2'd3};
        vecs[2] = '{npush: 15, exp_busy: 1'b0, exp_err: 1'b1, exp_code: 2'd3};
        vecs[3] = '{npush: 16, exp_busy: 1'b1, exp_err: 1'b0, exp_code: 2'd0};
        vecs[4] = '{npush: 17, exp_busy: 1'b1, exp_err: 1'b0, exp_code: 2'd0};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; start = 1'b0; abort = 1'b0;
        cpu_ready = 1'b0; cpu_done_load = 1'b0; cpu_halt = 1'b0; cpu_out = '0;
        tick;
        tick;
        check_all_zero("reset");
        rst = 1'b0;
        tick;

        // Start decision: short images, exact image, and a 17th push that is dropped
        for (int v = 0; v < 5; v++) begin
            push_bytes(8'h80, vecs[v].npush);
            check("pre_count", 32'(fifo_count), 32'(model_cnt));
            do_start;
            check("start_busy",  32'(busy), 32'(vecs[v].exp_busy));
            check("start_prog",  32'(cpu_programming), 32'(vecs[v].exp_busy));
            check("start_error", 32'(error), 32'(vecs[v].exp_err));
            check("start_code",  32'(err_code), 32'(vecs[v].exp_code));
            check("start_sready", 32'(s_ready), 32'd0);
            do_abort;
            check("abort_count", 32'(fifo_count), 32'd0);
            check("abort_error", 32'(error), 32'd0);
            check("abort_code",  32'(err_code), 32'd0);
            check("abort_busy",  32'(busy), 32'd0);
        end

        // Happy path
        push_bytes(8'h00, 16);
        check("full_sready", 32'(s_ready), 32'd0);
        do_start;
        for (int i = 0; i < 16; i++) cpu_byte;
        pulse_done;
        check("run_busy", 32'(busy), 32'd1);
        check("run_prog", 32'(cpu_programming), 32'd0);
        check("run_ui_in", 32'(cpu_ui_in), 32'd0);
        repeat (19) tick;
        check("run_not_halted", 32'(halted), 32'd0);
        do_halt(8'h2A);
        check("hp_halted", 32'(halted), 32'd1);
        check("hp_busy", 32'(busy), 32'd0);
        check("hp_result", 32'(result), 32'h2A);
        check("hp_cycles", 32'(run_cycles), 32'd20);
        repeat (3) tick;
        check("hp_cycles_hold", 32'(run_cycles), 32'd20);
        check("hp_result_hold", 32'(result), 32'h2A);
        do_abort;

        // Underrun: 17th byte request with an empty FIFO
        push_bytes(8'h10, 16);
        do_start;
        for (int i = 0; i < 16; i++) cpu_byte;
        cpu_ready = 1'b1;
        tick;
        cpu_ready = 1'b0;
        check("ur_prog_before", 32'(cpu_programming), 32'd1);
        tick;
        check("ur_error", 32'(error), 32'd1);
        check("ur_code",  32'(err_code), 32'd1);
        check("ur_prog",  32'(cpu_programming), 32'd0);
        do_abort;

        // Timeout measured from the last consume
        push_bytes(8'h30, 16);
        do_start;
        for (int i = 0; i < 3; i++) cpu_byte;
        cpu_ready = 1'b1;
        n = 0;
        while (n < TO + 10 && !error) begin
            tick;
            n++;
        end
        check("to_cycles", 32'(n), 32'(TO));
        check("to_code",   32'(err_code), 32'd2);
        check("to_count",  32'(fifo_count), 32'(model_cnt));
        cpu_ready = 1'b0;
        tick;
        do_abort;

        // Push coinciding with a consume; surplus byte survives the load
        push_bytes(8'h40, 16);
        do_start;
        cpu_byte;
        cpu_ready = 1'b1;
        tick;
        check("sim_ui_in", 32'(cpu_ui_in), 32'(exp_q.pop_front()));
        cpu_ready = 1'b0;
        s_data  = 8'h77;
        s_valid = 1'b1;
        check("sim_sready", 32'(s_ready), 32'd1);
        tick;
        s_valid = 1'b0;
        exp_q.push_back(8'h77);
        check("sim_count", 32'(fifo_count), 32'(model_cnt));
        for (int i = 0; i < 14; i++) cpu_byte;
        pulse_done;
        check("sim_surplus", 32'(fifo_count), 32'd1);
        do_halt(8'h5C);
        check("sim_result", 32'(result), 32'h5C);
        check("sim_cycles", 32'(run_cycles), 32'd1);
        do_abort;

        // Two back-to-back loads, second started from HALTED
        push_bytes(8'hA0, 16);
        do_start;
        for (int i = 0; i < 16; i++) cpu_byte;
        pulse_done;
        do_halt(8'h11);
        push_bytes(8'hB0, 16);
        do_start;
        check("wrap_prog", 32'(cpu_programming), 32'd1);
        for (int i = 0; i < 16; i++) cpu_byte;
        pulse_done;
        do_halt(8'h99);
        check("wrap_result", 32'(result), 32'h99);
        do_abort;

        // Reset during the fifth byte of a load
        push_bytes(8'h60, 16);
        do_start;
        for (int i = 0; i < 4; i++) cpu_byte;
        cpu_ready = 1'b1;
        tick;
        check("rst_ui_in", 32'(cpu_ui_in), 32'(exp_q.pop_front()));
        rst = 1'b1;
        cpu_ready = 1'b0;
        tick;
        check_all_zero("midrst");
        rst = 1'b0;
        model_cnt = 0;
        exp_q.delete();
        tick;

        // abort together with start in HALTED
        push_bytes(8'hC0, 16);
        do_start;
        for (int i = 0; i < 16; i++) cpu_byte;
        pulse_done;
        do_halt(8'h3C);
        push_bytes(8'hD0, 16);
        abort = 1'b1;
        start = 1'b1;
        tick;
        abort = 1'b0;
        start = 1'b0;
        model_cnt = 0;
        exp_q.delete();
        check("as_busy",   32'(busy), 32'd0);
        check("as_prog",   32'(cpu_programming), 32'd0);
        check("as_halted", 32'(halted), 32'd0);
        check("as_count",  32'(fifo_count), 32'd0);
        tick;
        check("as_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
